// File: rtl/ibex_instr_aligner.sv
// ibex_instr_aligner
//   Buffers word-aligned fetch responses and hands the compressed decoder one
//   instruction per beat, starting at the current PC. A 32-bit instruction may
//   straddle two buffered words. The block tracks the PC and flags fetch errors
//   per instruction.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   clear_i, clear_addr_i      flush the buffer and redirect the PC
//   in_valid_i/in_ready_o      fetch word handshake (in_rdata_i, in_err_i)
//   out_valid_o/out_ready_i    instruction handshake
//   out_rdata_o, out_addr_o    instruction and its PC
//   out_err_o, out_err_plus2_o instruction touched an errored word / only its upper half did
module ibex_instr_aligner #(
  parameter int unsigned Depth     = 2,
  parameter logic [31:0] ResetAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  localparam int unsigned     CntW   = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  logic [31:0]      data_q [Depth];
  logic [31:0]      data_d [Depth];
  logic [Depth-1:0] err_q, err_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic             ready_q;

  logic             e0_vld, e1_vld;
  logic [15:0]      lo_half;
  logic             is_comp;
  logic             avail, pop_req, inc4;
  logic             push, pop, consume;
  logic [CntW-1:0]  wr_idx;
  logic             unused_clear_addr0;

  assign unused_clear_addr0 = clear_addr_i[0];

  assign e0_vld  = (count_q != '0);
  assign e1_vld  = (count_q > CntW'(1));
  assign lo_half = pc_q[1] ? data_q[0][31:16] : data_q[0][15:0];
  assign is_comp = (lo_half[1:0] != 2'b11);

  // Decode: which entries are needed, what is presented, and how far the PC moves.
  always_comb begin
    avail           = 1'b0;
    out_rdata_o     = '0;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;
    pop_req         = 1'b0;
    inc4            = 1'b0;
    if (e0_vld) begin
      if (err_q[0]) begin
        // Errored oldest word: present immediately, never wait for e1.
        avail     = 1'b1;
        out_err_o = 1'b1;
        pop_req   = 1'b1;
        inc4      = ~pc_q[1];
      end else if (!pc_q[1]) begin
        avail       = 1'b1;
        out_rdata_o = data_q[0];
        pop_req     = ~is_comp;
        inc4        = ~is_comp;
      end else if (is_comp) begin
        avail       = 1'b1;
        out_rdata_o = {16'h0000, data_q[0][31:16]};
        pop_req     = 1'b1;
      end else if (e1_vld) begin
        // Straddling instruction: only e0 is popped, e1 becomes the new e0.
        avail           = 1'b1;
        out_rdata_o     = {data_q[1][15:0], data_q[0][31:16]};
        out_err_o       = err_q[1];
        out_err_plus2_o = err_q[1];
        pop_req         = 1'b1;
        inc4            = 1'b1;
      end
    end
  end

  assign out_valid_o = avail & ~clear_i;
  assign out_addr_o  = pc_q;
  assign in_ready_o  = ready_q;

  assign consume = out_valid_o & out_ready_i;
  assign pop     = consume & pop_req;
  assign push    = in_valid_i & ready_q & ~clear_i;
  assign wr_idx  = count_q - CntW'(pop);

  // Shift-register FIFO: entry 0 is always the oldest word.
  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < Depth; i++) begin
        data_d[i] = data_q[i+1];
        err_d[i]  = err_q[i+1];
      end
    end
    if (push) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (CntW'(i) == wr_idx) begin
          data_d[i] = in_rdata_i;
          err_d[i]  = in_err_i;
        end
      end
    end
    if (clear_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    if (clear_i) begin
      pc_d = {clear_addr_i[31:1], 1'b0};
    end else if (consume) begin
      pc_d = pc_q + (inc4 ? 32'd4 : 32'd2);
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '{default: '0};
      err_q   <= '0;
      count_q <= '0;
      pc_q    <= ResetAddr;
      ready_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      ready_q <= (count_d < DepthC);
    end
  end

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Self-checking bench for ibex_instr_aligner. The reference model keeps the
// fetched stream as a queue of halfwords starting at the current PC.
module tb_ibex_instr_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [31:0] clear_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  always #5 clk_i = ~clk_i;

  ibex_instr_aligner #(
    .Depth     (2),
    .ResetAddr (32'h0000_0000)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .clear_addr_i    (clear_addr_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_rdata_i      (in_rdata_i),
    .in_err_i        (in_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_rdata_o     (out_rdata_o),
    .out_addr_o      (out_addr_o),
    .out_err_o       (out_err_o),
    .out_err_plus2_o (out_err_plus2_o)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] h;
    logic        e;
  } half_t;

  half_t       hq[$];
  logic [31:0] m_pc;
  logic        m_ready;
  logic        m_skip;

  task automatic model_reset();
    hq.delete();
    m_pc    = 32'h0000_0000;
    m_ready = 1'b0;
    m_skip  = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] lo, hi;
    lo = 16'($urandom);
    hi = 16'($urandom);
    if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
    return {hi, lo};
  endfunction

  // One clock cycle: drive at posedge+1, compare at posedge+2, update model at the edge.
  task automatic cycle(input logic iv, input logic [31:0] wd, input logic we,
                       input logic ordy, input logic clr, input logic [31:0] caddr,
                       output logic accepted);
    logic        ev, eerr, ep2, ecomp;
    int          n;
    logic [31:0] einstr;
    in_valid_i   = iv;
    in_rdata_i   = wd;
    in_err_i     = we;
    out_ready_i  = ordy;
    clear_i      = clr;
    clear_addr_i = caddr;
    #1;
    ev = 1'b0; eerr = 1'b0; ep2 = 1'b0; ecomp = 1'b0; n = 0; einstr = '0;
    if (hq.size() > 0 && !clr) begin
      if (hq[0].e) begin
        ev = 1'b1; eerr = 1'b1; n = m_pc[1] ? 1 : 2;
      end else if (hq[0].h[1:0] != 2'b11) begin
        ev = 1'b1; ecomp = 1'b1; n = 1; einstr = {16'h0000, hq[0].h};
      end else if (hq.size() >= 2) begin
        ev = 1'b1; eerr = hq[1].e; ep2 = hq[1].e; n = 2; einstr = {hq[1].h, hq[0].h};
      end
    end
    check("in_ready", in_ready_o, m_ready);
    check("out_valid", out_valid_o, ev);
    if (ev) begin
      check("out_addr", out_addr_o, m_pc);
      check("out_err", out_err_o, eerr);
      check("out_err_plus2", out_err_plus2_o, ep2);
      if (!eerr) begin
        if (ecomp) check("rdata16", {16'h0000, out_rdata_o[15:0]}, einstr);
        else       check("rdata32", out_rdata_o, einstr);
      end
    end
    accepted = iv && m_ready && !clr;
    @(posedge clk_i);
    if (clr) begin
      hq.delete();
      m_pc   = {caddr[31:1], 1'b0};
      m_skip = caddr[1];
    end else begin
      if (ev && ordy) begin
        repeat (n) void'(hq.pop_front());
        m_pc = m_pc + 32'(2 * n);
      end
      if (accepted) begin
        if (!m_skip) hq.push_back(half_t'{h: wd[15:0], e: we});
        hq.push_back(half_t'{h: wd[31:16], e: we});
        m_skip = 1'b0;
      end
    end
    m_ready = ((hq.size() + int'(m_pc[1])) / 2) < 2;
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] words [3];
    int          idx;

    rst_ni = 1'b0; clear_i = 1'b0; clear_addr_i = '0; in_valid_i = 1'b0;
    in_rdata_i = '0; in_err_i = 1'b0; out_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_out_valid", out_valid_o, 1'b0);
    check("reset_out_err", out_err_o, 1'b0);
    check("reset_out_err_plus2", out_err_plus2_o, 1'b0);
    check("reset_out_addr", out_addr_o, 32'h0);
    rst_ni = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, acc);

    // Aligned stream
    cycle(1, 32'h0000_0013, 0, 1, 0, 0, acc);
    cycle(1, 32'h0010_0093, 0, 1, 0, 0, acc);
    repeat (3) cycle(0, 0, 0, 1, 0, 0, acc);
    check("aligned_pc", out_addr_o, 32'h8);

    // Compressed pair
    cycle(1, 32'h4505_4501, 0, 0, 0, 0, acc);
    check("comp_lo", {16'h0, out_rdata_o[15:0]}, 32'h4501);
    repeat (3) cycle(0, 0, 0, 1, 0, 0, acc);
    check("comp_pc", out_addr_o, 32'hC);

    // Straddle
    cycle(0, 0, 0, 0, 1, 32'h2, acc);
    cycle(1, 32'h0093_1234, 0, 1, 0, 0, acc);
    cycle(1, 32'h5678_0010, 0, 0, 0, 0, acc);
    check("straddle_valid", out_valid_o, 1'b1);
    check("straddle_rdata", out_rdata_o, 32'h0010_0093);
    check("straddle_addr", out_addr_o, 32'h2);
    cycle(0, 0, 0, 1, 0, 0, acc);
    check("straddle_pc", out_addr_o, 32'h6);
    repeat (2) cycle(0, 0, 0, 1, 0, 0, acc);

    // Straddle with errored second word
    cycle(0, 0, 0, 0, 1, 32'h2, acc);
    cycle(1, 32'h0093_0000, 0, 0, 0, 0, acc);
    cycle(1, 32'h0000_0010, 1, 0, 0, 0, acc);
    check("plus2_err", out_err_o, 1'b1);
    check("plus2_flag", out_err_plus2_o, 1'b1);
    repeat (3) cycle(0, 0, 0, 1, 0, 0, acc);

    // Errored first word presented without waiting for a second
    cycle(0, 0, 0, 0, 1, 32'h0, acc);
    cycle(1, 32'h0093_0013, 1, 0, 0, 0, acc);
    check("e0err_valid", out_valid_o, 1'b1);
    check("e0err_err", out_err_o, 1'b1);
    check("e0err_plus2", out_err_plus2_o, 1'b0);
    repeat (2) cycle(0, 0, 0, 1, 0, 0, acc);

    // Backpressure and full
    cycle(0, 0, 0, 0, 1, 32'h0, acc);
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113;
    idx = 0;
    repeat (4) begin
      cycle(1, words[idx], 0, 0, 0, 0, acc);
      if (acc && idx < 2) idx++;
    end
    check("full_accepts", idx, 2);
    check("full_ready", in_ready_o, 1'b0);
    for (int k = 0; k < 20 && idx < 3; k++) begin
      cycle(1, words[idx], 0, 1, 0, 0, acc);
      if (acc) idx++;
    end
    check("full_drained_in", idx, 3);
    repeat (4) cycle(0, 0, 0, 1, 0, 0, acc);
    check("full_pc", out_addr_o, 32'hC);

    // Clear while full with a push offered
    cycle(1, 32'h0000_0013, 0, 0, 0, 0, acc);
    cycle(1, 32'h0010_0093, 0, 0, 0, 0, acc);
    cycle(1, 32'hDEAD_BEEF, 0, 1, 1, 32'h100, acc);
    check("clear_addr", out_addr_o, 32'h100);
    cycle(0, 0, 0, 0, 0, 0, acc);
    cycle(1, 32'h0030_0193, 0, 1, 0, 0, acc);
    cycle(0, 0, 0, 1, 0, 0, acc);

    // PC wrap
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFE, acc);
    cycle(1, 32'h0001_0000, 0, 1, 0, 0, acc);
    cycle(0, 0, 0, 1, 0, 0, acc);
    check("wrap_pc", out_addr_o, 32'h0);

    // Asynchronous reset mid-stream
    cycle(1, 32'h0000_0013, 0, 0, 0, 0, acc);
    cycle(1, 32'h0010_0093, 0, 0, 0, 0, acc);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_out_valid", out_valid_o, 1'b0);
    check("arst_out_err", out_err_o, 1'b0);
    check("arst_out_err_plus2", out_err_plus2_o, 1'b0);
    check("arst_out_addr", out_addr_o, 32'h0);
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, acc);

    // Randomized stream
    for (int i = 0; i < 4000; i++) begin
      logic        clr;
      logic [31:0] caddr;
      clr   = ($urandom_range(0, 49) == 0);
      caddr = $urandom;
      if ($urandom_range(0, 3) == 0) caddr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, clr, caddr, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_instr_aligner.md
Name: ibex_instr_aligner

Overview:
- Fetch-side stage that sits directly upstream of the compressed decoder.
- Buffers 32-bit word-aligned fetch responses and realigns them into one instruction per output beat, starting at the current PC.
- A 16-bit instruction appears in bits [15:0]. A 32-bit instruction may straddle two fetch words.
- Tracks the PC, flags fetch errors per instruction, and flushes on a branch/exception clear.

Parameters:
- Depth, 2, number of buffered fetch words (>=2).
- ResetAddr, 32'h0000_0000, PC value loaded at reset (bit 0 must be 0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  flush buffer and redirect PC
- clear_addr_i  in  32  new PC on clear_i (bit 0 ignored)
- in_valid_i  in  1  fetch word valid
- in_ready_o  out  1  buffer can accept a word
- in_rdata_i  in  32  fetch word (word-aligned)
- in_err_i  in  1  bus error on this word
- out_valid_o  out  1  aligned instruction available
- out_ready_i  in  1  consumer accepts instruction
- out_rdata_o  out  32  instruction; bits [31:16] don't-care when compressed
- out_addr_o  out  32  PC of out_rdata_o
- out_err_o  out  1  instruction touched an errored word
- out_err_plus2_o  out  1  error lies only in the second half of a straddling instruction

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: FIFO count=0; PC=ResetAddr; out_valid_o=0; out_err_o=0; out_err_plus2_o=0; in_ready_o=1 one cycle after reset release.
- FIFO:
  - In-order word FIFO: entries {data, err}; e0 = oldest, e1 = next.
  - Push on in_valid_i && in_ready_o. in_ready_o = (count < Depth), registered only; no path from out_ready_i.
  - Simultaneous push and pop keeps count.
- Output decode (combinational from FIFO and PC). Compressed = low half [1:0] != 2'b11.
  - PC[1]=0: needs e0. out_rdata_o = e0.data.
  - PC[1]=1, e0.data[17:16] != 11: needs e0. out_rdata_o = {16'h0, e0.data[31:16]}.
  - PC[1]=1, uncompressed: needs e0 and e1. out_rdata_o = {e1.data[15:0], e0.data[31:16]}.
  - out_valid_o = required entries present && !clear_i.
  - Latency: a word pushed in cycle N can be presented in cycle N+1.
- Errors:
  - e0.err=1: out_valid_o as soon as e0 is present (never waits for e1); out_err_o=1, out_err_plus2_o=0; out_rdata_o don't-care.
  - Straddling with e0 clean and e1.err=1: out_err_o=1, out_err_plus2_o=1.
  - All other cases: both 0.
- Consume on out_valid_o && out_ready_i:
  - PC[1]=0, compressed: no pop, PC+=2.
  - PC[1]=0, uncompressed: pop e0, PC+=4.
  - PC[1]=1, compressed: pop e0, PC+=2.
  - PC[1]=1, uncompressed: pop e0 only (e1 stays as new e0), PC+=4.
  - Errored e0: pop e0; PC advances per decode of available bits (PC+=2 if PC[1]=1, else +4). The controller is expected to redirect anyway.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFE+2 -> 0.
- clear_i:
  - Highest priority. Next cycle: count=0, PC={clear_addr_i[31:1],1'b0}.
  - In the clear cycle, any input push and any output consume are discarded.
  - If the new PC[1]=1, the low half of the first word is skipped through the normal decode.
- Mid-operation rst_ni: immediate asynchronous return to reset values.
- Full: in_ready_o=0, in_rdata_i ignored. Empty: out_valid_o=0; out_rdata_o, out_err_o and out_err_plus2_o are held low/don't-care.
- Output stability: once out_valid_o=1 without out_ready_i, outputs stay stable until consumed or cleared.

Test Plan:
- Aligned stream: push 32'h0000_0013 then 32'h0010_0093 at PC 0 -> two beats, addr 0 then 4, rdata matches, count returns to 0.
- Compressed pair: push 32'h4505_4501 -> beat rdata[15:0]=16'h4501 @0, then 16'h4505 @2, then word popped; in_ready_o stays 1.
- Straddle: PC=0x2 via clear, push 32'h0093_xxxx then 32'hxxxx_0010 -> no output after first word; after second word rdata=32'h0010_0093 @2; second word kept, PC=6.
- Errors: straddle with second word in_err_i=1 -> out_err_o=1, out_err_plus2_o=1; first word errored -> out_err_o=1, plus2=0, beat without waiting for second word.
- Backpressure and full: Depth=2, out_ready_i=0, push 3 words -> in_ready_o drops after 2, third held by source; output stable; release -> in-order drain.
- Clear and reset: clear_i with clear_addr_i=32'h100 while full and in_valid_i=1 -> next cycle count=0, out_valid_o=0, PC=0x100, input word dropped. Assert rst_ni mid-stream -> all outputs at reset values asynchronously.
